// File: rtl/rob_queue_pkg.sv
// Shared ROB sizing, exception encoding and the per-entry bookkeeping record.
package rob_queue_pkg;
    localparam int ROB_ADDR_W  = 4;
    localparam int ROB_DEPTH   = 2 ** ROB_ADDR_W;
    localparam int ROB_COUNT_W = ROB_ADDR_W + 1;

    localparam int EXC_TYPE_W = 4;
    localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_NULL = '0;

    // Fields captured at allocation; the result word is stored separately.
    typedef struct packed {
        logic                  reg_write_en;
        logic [4:0]            reg_write_addr;
        logic [EXC_TYPE_W-1:0] exception_type;
        logic                  is_delayslot;
        logic [31:0]           pc;
    } rob_entry_t;
endpackage

// File: rtl/rob_read_port.sv
// One operand-lookup port: stored result, or the writeback arriving this cycle.
module rob_read_port #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic [2**ADDR_WIDTH-1:0]                 valid,
    input  logic [2**ADDR_WIDTH-1:0]                 done,
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] entry_data,
    input  logic                                     wb_en,
    input  logic [ADDR_WIDTH-1:0]                    wb_addr,
    input  logic [DATA_WIDTH-1:0]                    wb_data,
    input  logic [ADDR_WIDTH-1:0]                    read_addr,
    output logic                                     ready,
    output logic [DATA_WIDTH-1:0]                    data
);
    logic bypass;

    // A writeback to a flushed slot must not look like a live result.
    assign bypass = wb_en && (wb_addr == read_addr) && valid[read_addr];

    always_comb begin
        ready = bypass || (valid[read_addr] && done[read_addr]);
        data  = bypass ? wb_data : entry_data[read_addr];
    end
endmodule

// File: rtl/rob_queue.sv
// Circular reorder buffer: in-order allocate, out-of-order completion, in-order commit.
module rob_queue
    import rob_queue_pkg::*;
#(
    parameter int ADDR_WIDTH = ROB_ADDR_W,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  write_en,
    output logic                  can_write,
    output logic [ADDR_WIDTH-1:0] write_addr,
    input  logic                  write_reg_write_en,
    input  logic [4:0]            write_reg_write_addr,
    input  logic [EXC_TYPE_W-1:0] write_exception_type,
    input  logic                  write_is_delayslot,
    input  logic [31:0]           write_pc,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  commit_en,
    output logic                  can_commit,
    output logic                  commit_reg_write_en,
    output logic [4:0]            commit_reg_write_addr,
    output logic [DATA_WIDTH-1:0] commit_reg_write_data,
    output logic [EXC_TYPE_W-1:0] commit_exception_type,
    output logic                  commit_is_delayslot,
    output logic [31:0]           commit_pc,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    output logic                  read_ready_1,
    output logic                  read_ready_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DEPTH-1:0]                 valid;
    logic [DEPTH-1:0]                 done;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data;
    rob_entry_t                       ent [DEPTH];

    logic [ADDR_WIDTH-1:0] head, tail;
    logic [ADDR_WIDTH:0]   count;
    logic                  live, do_alloc, do_commit, do_wb;

    assign can_write  = (count != FULL_CNT);
    assign write_addr = tail;
    assign can_commit = (count != '0) && done[head];

    // Reset and flush both shadow every state update in the same cycle.
    assign live      = rst && !flush;
    assign do_alloc  = live && write_en && can_write;
    assign do_commit = live && commit_en && can_commit;
    assign do_wb     = live && wb_en && valid[wb_addr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            valid <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_wb)
                done[wb_addr] <= 1'b1;
            // Committing clears the head after any same-cycle writeback to it.
            if (do_commit) begin
                valid[head] <= 1'b0;
                done[head]  <= 1'b0;
                head        <= head + 1'b1;
            end
            // Faulting instructions never execute, so they are born complete.
            if (do_alloc) begin
                valid[tail] <= 1'b1;
                done[tail]  <= (write_exception_type != EXC_TYPE_NULL);
                tail        <= tail + 1'b1;
            end
            if (do_alloc && !do_commit)
                count <= count + 1'b1;
            else if (do_commit && !do_alloc)
                count <= count - 1'b1;
        end
    end

    // Payload storage carries no reset; valid/done decide what is meaningful.
    always_ff @(posedge clk) begin
        if (do_wb)
            data[wb_addr] <= wb_data;
        if (do_alloc)
            ent[tail] <= '{reg_write_en:   write_reg_write_en,
                           reg_write_addr: write_reg_write_addr,
                           exception_type: write_exception_type,
                           is_delayslot:   write_is_delayslot,
                           pc:             write_pc};
    end

    always_comb begin
        commit_reg_write_en   = ent[head].reg_write_en;
        commit_reg_write_addr = ent[head].reg_write_addr;
        commit_reg_write_data = data[head];
        commit_exception_type = ent[head].exception_type;
        commit_is_delayslot   = ent[head].is_delayslot;
        commit_pc             = ent[head].pc;
    end

    logic [1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]                 rd_ready;
    logic [1:0][DATA_WIDTH-1:0] rd_data;

    assign rd_addr      = {read_addr_2, read_addr_1};
    assign read_ready_1 = rd_ready[0];
    assign read_ready_2 = rd_ready[1];
    assign read_data_1  = rd_data[0];
    assign read_data_2  = rd_data[1];

    for (genvar g = 0; g < 2; g++) begin : g_rd
        rob_read_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_rd (
            .valid      (valid),
            .done       (done),
            .entry_data (data),
            .wb_en      (wb_en),
            .wb_addr    (wb_addr),
            .wb_data    (wb_data),
            .read_addr  (rd_addr[g]),
            .ready      (rd_ready[g]),
            .data       (rd_data[g])
        );
    end
endmodule

// File: tb/tb_rob_queue.sv
// Directed scenarios plus a randomized run against a slot-array/queue reference model.
module tb_rob_queue;
    import rob_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        write_en = 1'b0;
    logic        can_write;
    logic [3:0]  write_addr;
    logic        write_reg_write_en = 1'b0;
    logic [4:0]  write_reg_write_addr = '0;
    logic [3:0]  write_exception_type = '0;
    logic        write_is_delayslot = 1'b0;
    logic [31:0] write_pc = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        commit_en = 1'b0;
    logic        can_commit;
    logic        commit_reg_write_en;
    logic [4:0]  commit_reg_write_addr;
    logic [31:0] commit_reg_write_data;
    logic [3:0]  commit_exception_type;
    logic        commit_is_delayslot;
    logic [31:0] commit_pc;
    logic [3:0]  read_addr_1 = '0, read_addr_2 = '0;
    logic        read_ready_1, read_ready_2;
    logic [31:0] read_data_1, read_data_2;

    int pass_cnt = 0;
    int total_cnt = 0;

    rob_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .write_en(write_en), .can_write(can_write), .write_addr(write_addr),
        .write_reg_write_en(write_reg_write_en), .write_reg_write_addr(write_reg_write_addr),
        .write_exception_type(write_exception_type), .write_is_delayslot(write_is_delayslot),
        .write_pc(write_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .commit_en(commit_en), .can_commit(can_commit),
        .commit_reg_write_en(commit_reg_write_en), .commit_reg_write_addr(commit_reg_write_addr),
        .commit_reg_write_data(commit_reg_write_data), .commit_exception_type(commit_exception_type),
        .commit_is_delayslot(commit_is_delayslot), .commit_pc(commit_pc),
        .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
        .read_ready_1(read_ready_1), .read_ready_2(read_ready_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2)
    );

    always #5 clk = ~clk;

    // Reference model: per-slot contents plus head index and occupancy.
    bit          m_valid [16];
    bit          m_done  [16];
    logic [31:0] m_data  [16];
    rob_entry_t  m_ent   [16];
    int          m_head, m_count;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_done[i]  = 0;
        end
        m_head  = 0;
        m_count = 0;
    endtask

    // Applies the clock-edge rules to the model using the inputs now on the pins.
    task automatic model_step();
        bit cc, cw;
        int t;
        if (!rst || flush) begin
            model_clear();
        end else begin
            cc = (m_count != 0) && m_done[m_head];
            cw = (m_count != 16);
            t  = (m_head + m_count) % 16;
            if (wb_en && m_valid[wb_addr]) begin
                m_data[wb_addr] = wb_data;
                m_done[wb_addr] = 1;
            end
            if (commit_en && cc) begin
                m_valid[m_head] = 0;
                m_done[m_head]  = 0;
                m_head  = (m_head + 1) % 16;
                m_count = m_count - 1;
            end
            if (write_en && cw) begin
                m_ent[t].reg_write_en   = write_reg_write_en;
                m_ent[t].reg_write_addr = write_reg_write_addr;
                m_ent[t].exception_type = write_exception_type;
                m_ent[t].is_delayslot   = write_is_delayslot;
                m_ent[t].pc             = write_pc;
                m_valid[t] = 1;
                m_done[t]  = (write_exception_type != EXC_TYPE_NULL);
                m_count    = m_count + 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; write_en = 0; wb_en = 0; commit_en = 0;
        write_exception_type = EXC_TYPE_NULL;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        tick();
        rst = 1;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic [4:0] rd, input logic [3:0] exc);
        write_en = 1;
        write_pc = pc;
        write_reg_write_en = 1;
        write_reg_write_addr = rd;
        write_exception_type = exc;
        write_is_delayslot = pc[2];
    endtask

    task automatic test_reset();
        do_reset();
        read_addr_1 = 4'd0; read_addr_2 = 4'd9;
        #1;
        total_cnt++; if (can_write !== 1'b1) $display("FAIL reset_can_write got %0b want 1", can_write); else pass_cnt++;
        total_cnt++; if (write_addr !== 4'd0) $display("FAIL reset_write_addr got %0d want 0", write_addr); else pass_cnt++;
        total_cnt++; if (can_commit !== 1'b0) $display("FAIL reset_can_commit got %0b want 0", can_commit); else pass_cnt++;
        total_cnt++; if (read_ready_1 !== 1'b0 || read_ready_2 !== 1'b0)
            $display("FAIL reset_read_ready got %0b%0b want 00", read_ready_1, read_ready_2); else pass_cnt++;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_alloc(32'h1000 + 4 * i, 5'(i), EXC_TYPE_NULL);
            #1;
            total_cnt++; if (write_addr !== 4'(i) || can_write !== 1'b1)
                $display("FAIL fill_addr_%0d got addr %0d can_write %0b want %0d 1", i, write_addr, can_write, i);
            else pass_cnt++;
            tick();
        end
        idle_inputs();
        #1;
        total_cnt++; if (can_write !== 1'b0) $display("FAIL full_can_write got %0b want 0", can_write); else pass_cnt++;
        set_alloc(32'hDEAD0000, 5'd1, EXC_TYPE_NULL);
        tick();
        idle_inputs();
        #1;
        total_cnt++; if (can_write !== 1'b0 || write_addr !== 4'd0 || can_commit !== 1'b0)
            $display("FAIL full_ignore got can_write %0b addr %0d can_commit %0b want 0 0 0", can_write, write_addr, can_commit);
        else pass_cnt++;
    endtask

    task automatic test_wb_commit();
        do_reset();
        set_alloc(32'hBFC00000, 5'd5, EXC_TYPE_NULL);
        tick();
        idle_inputs();
        wb_en = 1; wb_addr = 4'd0; wb_data = 32'h1234;
        #1;
        total_cnt++; if (can_commit !== 1'b0) $display("FAIL wb_same_cycle_commit got %0b want 0", can_commit); else pass_cnt++;
        tick();
        wb_en = 0;
        #1;
        total_cnt++; if (can_commit !== 1'b1) $display("FAIL wb_next_commit got %0b want 1", can_commit); else pass_cnt++;
        total_cnt++; if (commit_reg_write_data !== 32'h1234 || commit_reg_write_addr !== 5'd5 || commit_pc !== 32'hBFC00000)
            $display("FAIL wb_commit_fields got data %h reg %0d pc %h want 1234 5 bfc00000",
                     commit_reg_write_data, commit_reg_write_addr, commit_pc);
        else pass_cnt++;
        commit_en = 1;
        tick();
        commit_en = 0;
        #1;
        total_cnt++; if (can_commit !== 1'b0 || write_addr !== 4'd1)
            $display("FAIL after_commit got can_commit %0b addr %0d want 0 1", can_commit, write_addr); else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_alloc(32'h2000 + 4 * i, 5'd3, EXC_TYPE_NULL);
            tick();
        end
        idle_inputs();
        wb_en = 1; wb_addr = 4'd0; wb_data = 32'h55;
        tick();
        wb_en = 0; commit_en = 1;
        tick();
        commit_en = 0;
        #1;
        total_cnt++; if (can_write !== 1'b1 || write_addr !== 4'd0)
            $display("FAIL wrap_freed got can_write %0b addr %0d want 1 0", can_write, write_addr); else pass_cnt++;
        set_alloc(32'h3000, 5'd4, EXC_TYPE_NULL);
        tick();
        idle_inputs();
        #1;
        total_cnt++; if (can_write !== 1'b0 || write_addr !== 4'd1 || can_commit !== 1'b0)
            $display("FAIL wrap_tail got can_write %0b addr %0d can_commit %0b want 0 1 0", can_write, write_addr, can_commit);
        else pass_cnt++;
    endtask

    task automatic test_exception();
        do_reset();
        set_alloc(32'h4000, 5'd7, 4'd3);
        tick();
        idle_inputs();
        #1;
        total_cnt++; if (can_commit !== 1'b1 || commit_exception_type !== 4'd3)
            $display("FAIL exc_commit got can_commit %0b exc %0d want 1 3", can_commit, commit_exception_type); else pass_cnt++;
    endtask

    task automatic test_bypass();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc(32'h5000 + 4 * i, 5'd2, EXC_TYPE_NULL);
            tick();
        end
        idle_inputs();
        read_addr_1 = 4'd3; read_addr_2 = 4'd2;
        wb_en = 1; wb_addr = 4'd3; wb_data = 32'hDEAD;
        #1;
        total_cnt++; if (read_ready_1 !== 1'b1 || read_data_1 !== 32'hDEAD)
            $display("FAIL bypass got ready %0b data %h want 1 dead", read_ready_1, read_data_1); else pass_cnt++;
        total_cnt++; if (read_ready_2 !== 1'b0) $display("FAIL bypass_other got %0b want 0", read_ready_2); else pass_cnt++;
        tick();
        wb_en = 1; wb_addr = 4'd9; wb_data = 32'h99; read_addr_2 = 4'd9;
        #1;
        total_cnt++; if (read_ready_1 !== 1'b1 || read_data_1 !== 32'hDEAD)
            $display("FAIL stored_read got ready %0b data %h want 1 dead", read_ready_1, read_data_1); else pass_cnt++;
        total_cnt++; if (read_ready_2 !== 1'b0) $display("FAIL bypass_invalid got %0b want 0", read_ready_2); else pass_cnt++;
        tick();
        wb_en = 0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(32'h6000 + 4 * i, 5'd6, EXC_TYPE_NULL);
            tick();
        end
        idle_inputs();
        wb_en = 1; wb_addr = 4'd0; wb_data = 32'h77;
        tick();
        flush = 1; commit_en = 1; wb_addr = 4'd1;
        set_alloc(32'h7000, 5'd8, EXC_TYPE_NULL);
        tick();
        idle_inputs();
        wb_en = 1; wb_addr = 4'd2; wb_data = 32'hABCD; read_addr_1 = 4'd2;
        #1;
        total_cnt++; if (can_commit !== 1'b0 || write_addr !== 4'd0 || can_write !== 1'b1)
            $display("FAIL flush_state got can_commit %0b addr %0d can_write %0b want 0 0 1", can_commit, write_addr, can_write);
        else pass_cnt++;
        total_cnt++; if (read_ready_1 !== 1'b0) $display("FAIL flush_bypass got %0b want 0", read_ready_1); else pass_cnt++;
        tick();
        wb_en = 0;
        #1;
        total_cnt++; if (read_ready_1 !== 1'b0 || can_commit !== 1'b0)
            $display("FAIL flush_stale_wb got ready %0b can_commit %0b want 0 0", read_ready_1, can_commit); else pass_cnt++;
    endtask

    task automatic test_random();
        bit er1, er2, byp;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            flush = ($urandom_range(0, 99) < 2);
            write_en = ($urandom_range(0, 99) < 60);
            write_pc = $urandom;
            write_reg_write_en = 1'($urandom);
            write_reg_write_addr = 5'($urandom);
            write_exception_type = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : EXC_TYPE_NULL;
            write_is_delayslot = 1'($urandom);
            wb_en = 1'($urandom);
            wb_addr = (m_count != 0 && $urandom_range(0, 9) < 8) ?
                      4'((m_head + $urandom_range(0, m_count - 1)) % 16) : 4'($urandom);
            wb_data = $urandom;
            commit_en = ($urandom_range(0, 99) < 50);
            read_addr_1 = $urandom_range(0, 1) ? wb_addr : 4'($urandom);
            read_addr_2 = 4'($urandom);
            #1;
            total_cnt++; if (can_write !== (m_count != 16) || write_addr !== 4'((m_head + m_count) % 16))
                $display("FAIL rnd_write c%0d got can_write %0b addr %0d want %0b %0d", c, can_write, write_addr,
                         m_count != 16, (m_head + m_count) % 16);
            else pass_cnt++;
            total_cnt++; if (can_commit !== (m_count != 0 && m_done[m_head]))
                $display("FAIL rnd_can_commit c%0d got %0b want %0b", c, can_commit, m_count != 0 && m_done[m_head]);
            else pass_cnt++;
            if (m_count != 0) begin
                total_cnt++; if (commit_pc !== m_ent[m_head].pc || commit_reg_write_addr !== m_ent[m_head].reg_write_addr ||
                                 commit_reg_write_en !== m_ent[m_head].reg_write_en ||
                                 commit_exception_type !== m_ent[m_head].exception_type ||
                                 commit_is_delayslot !== m_ent[m_head].is_delayslot)
                    $display("FAIL rnd_commit_fields c%0d got pc %h reg %0d exc %0d want pc %h reg %0d exc %0d", c,
                             commit_pc, commit_reg_write_addr, commit_exception_type,
                             m_ent[m_head].pc, m_ent[m_head].reg_write_addr, m_ent[m_head].exception_type);
                else pass_cnt++;
                if (m_done[m_head] && m_ent[m_head].exception_type == EXC_TYPE_NULL) begin
                    total_cnt++; if (commit_reg_write_data !== m_data[m_head])
                        $display("FAIL rnd_commit_data c%0d got %h want %h", c, commit_reg_write_data, m_data[m_head]);
                    else pass_cnt++;
                end
            end
            byp = wb_en && wb_addr == read_addr_1 && m_valid[read_addr_1];
            er1 = byp || (m_valid[read_addr_1] && m_done[read_addr_1]);
            total_cnt++; if (read_ready_1 !== er1)
                $display("FAIL rnd_ready_1 c%0d got %0b want %0b", c, read_ready_1, er1); else pass_cnt++;
            if (er1 && m_ent[read_addr_1].exception_type == EXC_TYPE_NULL) begin
                total_cnt++; if (read_data_1 !== (byp ? wb_data : m_data[read_addr_1]))
                    $display("FAIL rnd_data_1 c%0d got %h want %h", c, read_data_1, byp ? wb_data : m_data[read_addr_1]);
                else pass_cnt++;
            end
            byp = wb_en && wb_addr == read_addr_2 && m_valid[read_addr_2];
            er2 = byp || (m_valid[read_addr_2] && m_done[read_addr_2]);
            total_cnt++; if (read_ready_2 !== er2)
                $display("FAIL rnd_ready_2 c%0d got %0b want %0b", c, read_ready_2, er2); else pass_cnt++;
            if (er2 && m_ent[read_addr_2].exception_type == EXC_TYPE_NULL) begin
                total_cnt++; if (read_data_2 !== (byp ? wb_data : m_data[read_addr_2]))
                    $display("FAIL rnd_data_2 c%0d got %h want %h", c, read_data_2, byp ? wb_data : m_data[read_addr_2]);
                else pass_cnt++;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fill();
        test_wb_commit();
        test_wrap();
        test_exception();
        test_bypass();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
